// File: rtl/copro_host_if.sv
// Request/response port between the bus adapter and copro_host, and the
// start/ready/push/pop port between copro_host and the multiply coprocessor.

interface copro_req_if;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [63:0] rsp_prod;
  logic        rsp_err;

  modport master (
    output req_vld, req_a, req_b, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_prod, rsp_err
  );

  modport slave (
    input  req_vld, req_a, req_b, rsp_rdy,
    output req_rdy, rsp_vld, rsp_prod, rsp_err
  );
endinterface

interface copro_bus_if;
  logic        start;
  logic        ready;
  logic        dpsh;
  logic        dpop;
  logic [31:0] dinp;
  logic [31:0] dout;

  modport master (
    output start, dpsh, dpop, dinp,
    input  ready, dout
  );

  modport slave (
    input  start, dpsh, dpop, dinp,
    output ready, dout
  );
endinterface

// File: rtl/copro_host.sv
// Host-side initiator for the multiply coprocessor: pushes A and B, starts it,
// waits for a fresh ready edge, pops hi/lo and returns the 64-bit product.

module copro_host #(
  parameter int GAP_CYC = 1,
  parameter int POP_LAT = 1,
  parameter int TMO_CYC = 1023
) (
  input  logic       ck,
  input  logic       rs,
  copro_req_if.slave req,
  copro_bus_if.master bus
);

  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PSH_A, S_PSH_B, S_GAP, S_STRT, S_WAIT, S_POP, S_CAPT, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          req_rdy_q, req_rdy_d;
  logic          start_q, start_d;
  logic          dpsh_q, dpsh_d;
  logic          dpop_q, dpop_d;
  logic [31:0]   dinp_q, dinp_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic          rsp_err_q, rsp_err_d;
  logic [63:0]   rsp_prod_q, rsp_prod_d;
  logic [31:0]   op_b_q, op_b_d;
  logic [31:0]   hi_q, hi_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          wsel_q, wsel_d;
  logic          pop2_q, pop2_d;
  logic          ready_q;
  logic [POP_LAT-1:0] pop_sr_q;
  logic          sample;

  // A popped word is on dout exactly POP_LAT cycles after its dpop cycle.
  assign sample = pop_sr_q[POP_LAT-1];

  assign req.req_rdy  = req_rdy_q;
  assign req.rsp_vld  = rsp_vld_q;
  assign req.rsp_err  = rsp_err_q;
  assign req.rsp_prod = rsp_prod_q;
  assign bus.start    = start_q;
  assign bus.dpsh     = dpsh_q;
  assign bus.dpop     = dpop_q;
  assign bus.dinp     = dinp_q;

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      state_q    <= S_IDLE;
      req_rdy_q  <= 1'b1;
      start_q    <= 1'b0;
      dpsh_q     <= 1'b0;
      dpop_q     <= 1'b0;
      dinp_q     <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_prod_q <= '0;
      op_b_q     <= '0;
      hi_q       <= '0;
      gap_q      <= '0;
      tmr_q      <= '0;
      wsel_q     <= 1'b0;
      pop2_q     <= 1'b0;
      ready_q    <= 1'b0;
      pop_sr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_rdy_q  <= req_rdy_d;
      start_q    <= start_d;
      dpsh_q     <= dpsh_d;
      dpop_q     <= dpop_d;
      dinp_q     <= dinp_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_prod_q <= rsp_prod_d;
      op_b_q     <= op_b_d;
      hi_q       <= hi_d;
      gap_q      <= gap_d;
      tmr_q      <= tmr_d;
      wsel_q     <= wsel_d;
      pop2_q     <= pop2_d;
      ready_q    <= bus.ready;
      pop_sr_q[0] <= dpop_q;
      for (int i = 1; i < POP_LAT; i++) begin
        pop_sr_q[i] <= pop_sr_q[i-1];
      end
    end
  end

  // Next-state logic also computes next values of every registered output,
  // so the coprocessor and requester only ever see flop outputs.
  always_comb begin
    state_d    = state_q;
    req_rdy_d  = 1'b0;
    start_d    = 1'b0;
    dpsh_d     = 1'b0;
    dpop_d     = 1'b0;
    dinp_d     = '0;
    rsp_vld_d  = rsp_vld_q;
    rsp_err_d  = rsp_err_q;
    rsp_prod_d = rsp_prod_q;
    op_b_d     = op_b_q;
    hi_d       = hi_q;
    gap_d      = gap_q;
    tmr_d      = tmr_q;
    wsel_d     = wsel_q;
    pop2_d     = pop2_q;

    if (sample && !wsel_q) begin
      hi_d   = bus.dout;
      wsel_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        req_rdy_d = 1'b1;
        if (req.req_vld) begin
          op_b_d    = req.req_b;
          dinp_d    = req.req_a;
          dpsh_d    = 1'b1;
          wsel_d    = 1'b0;
          req_rdy_d = 1'b0;
          state_d   = S_PSH_A;
        end
      end
      S_PSH_A: begin
        dpsh_d  = 1'b1;
        dinp_d  = op_b_q;
        state_d = S_PSH_B;
      end
      S_PSH_B: begin
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          start_d = 1'b1;
          tmr_d   = '0;
          state_d = S_STRT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_STRT: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      // Only a low->high transition counts; a level left over from an
      // earlier job must not be mistaken for completion.
      S_WAIT: begin
        if (bus.ready && !ready_q) begin
          dpop_d  = 1'b1;
          pop2_d  = 1'b0;
          state_d = S_POP;
        end else if (tmr_q == TW'(TMO_CYC - 1)) begin
          rsp_vld_d  = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_prod_d = '0;
          state_d    = S_RESP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_POP: begin
        if (!pop2_q) begin
          dpop_d = 1'b1;
          pop2_d = 1'b1;
        end else begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (sample && wsel_q) begin
          rsp_prod_d = {hi_q, bus.dout};
          rsp_vld_d  = 1'b1;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (req.rsp_rdy) begin
          rsp_vld_d = 1'b0;
          rsp_err_d = 1'b0;
          req_rdy_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
